// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_t;

    // Register word offsets, decoded from adr[3:2]
    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;

    localparam int unsigned STAT_NEMPTY_BIT = 0;
    localparam int unsigned STAT_PERR_BIT   = 1;
    localparam int unsigned STAT_FERR_BIT   = 2;
    localparam int unsigned STAT_OVF_BIT    = 3;
    localparam int unsigned STAT_COUNT_LSB  = 8;

    localparam int unsigned CTRL_IE_BIT    = 0;
    localparam int unsigned CTRL_FLUSH_BIT = 1;

    localparam int unsigned FILTER_LEN  = 4;
    localparam int unsigned TIMEOUT_DIV = 500;

endpackage

// File: rtl/if_wb.sv
// 32-bit Wishbone bus bundle; dat_i carries write data into the slave.
interface if_wb;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat_i;
    logic [31:0] dat_o;
    logic        ack;

    modport master (output cyc, stb, we, adr, dat_i, input dat_o, ack);
    modport slave  (input cyc, stb, we, adr, dat_i, output dat_o, ack);
endinterface

// File: rtl/ps2_fifo.sv
// Synchronous byte FIFO with flush; a push while full is only taken alongside a pop.
module ps2_fifo #(
    parameter int unsigned AW = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        i_push,
    input  logic [7:0]  i_wdata,
    input  logic        i_pop,
    input  logic        i_flush,
    output logic [7:0]  o_rdata_c,
    output logic        o_full_c,
    output logic        o_empty_c,
    output logic [AW:0] o_count
);

    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned CW    = AW + 1;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          w_push_ok;
    logic          w_pop_ok;

    assign o_empty_c = (r_count == '0);
    assign o_full_c  = (r_count == CW'(DEPTH));
    assign o_rdata_c = r_mem[r_rptr];
    assign o_count   = r_count;
    assign w_pop_ok  = i_pop & ~o_empty_c;
    assign w_push_ok = i_push & (~o_full_c | w_pop_ok);

    always_ff @(posedge clk_i) begin
        if (w_push_ok) r_mem[r_wptr] <= i_wdata;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push_ok) r_wptr <= r_wptr + AW'(1);
            if (w_pop_ok)  r_rptr <= r_rptr + AW'(1);
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ps2_kbd.sv
// Receive-only PS/2 keyboard controller: filtered line sampling, frame FSM,
// byte FIFO and a small Wishbone register file with a level interrupt.
module ps2_kbd
    import ps2_pkg::*;
#(
    parameter int unsigned CLKFREQ     = 10000000,
    parameter int unsigned FIFO_AWIDTH = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    if_wb.slave  bus,
    input  logic ps2_clk,
    input  logic ps2_dat,
    output logic interrupt
);

    localparam int unsigned TIMEOUT = CLKFREQ / TIMEOUT_DIV;
    localparam int unsigned TW      = $clog2(TIMEOUT);
    localparam int unsigned CW      = FIFO_AWIDTH + 1;

    logic [1:0]            r_clk_sync;
    logic [1:0]            r_dat_sync;
    logic [FILTER_LEN-1:0] r_clk_hist;
    logic [FILTER_LEN-1:0] r_dat_hist;
    logic                  r_clk_filt;
    logic                  r_dat_filt;
    logic                  r_fall;

    rx_state_t             r_state;
    logic [2:0]            r_bitcnt;
    logic [7:0]            r_shift;
    logic                  r_par;
    logic [TW-1:0]         r_timer;
    logic                  r_push;
    logic                  r_perr_set;
    logic                  r_ferr_set;

    logic                  r_ack;
    logic [31:0]           r_dat_o;
    logic                  r_ie;
    logic                  r_perr;
    logic                  r_ferr;
    logic                  r_ovf;
    logic                  r_irq;

    logic                  w_req;
    logic                  w_wr;
    logic                  w_rd;
    logic [1:0]            w_sel;
    logic                  w_pop;
    logic                  w_flush;
    logic [3:1]            w_clr;
    logic                  w_ovf_set;
    logic [31:0]           w_rdata;
    logic [7:0]            w_fifo_data;
    logic                  w_full;
    logic                  w_empty;
    logic [CW-1:0]         w_count;
    logic                  w_unused_ok;

    // Synchronize and filter both lines; a level moves only after FILTER_LEN equal samples
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_clk_sync <= '1;
            r_dat_sync <= '1;
            r_clk_hist <= '1;
            r_dat_hist <= '1;
            r_clk_filt <= 1'b1;
            r_dat_filt <= 1'b1;
            r_fall     <= 1'b0;
        end else begin
            r_clk_sync <= {r_clk_sync[0], ps2_clk};
            r_dat_sync <= {r_dat_sync[0], ps2_dat};
            r_clk_hist <= {r_clk_hist[FILTER_LEN-2:0], r_clk_sync[1]};
            r_dat_hist <= {r_dat_hist[FILTER_LEN-2:0], r_dat_sync[1]};
            if (&r_clk_hist)      r_clk_filt <= 1'b1;
            else if (~|r_clk_hist) r_clk_filt <= 1'b0;
            if (&r_dat_hist)      r_dat_filt <= 1'b1;
            else if (~|r_dat_hist) r_dat_filt <= 1'b0;
            r_fall <= r_clk_filt & ~|r_clk_hist;
        end
    end

    // Frame receiver; any non-idle state times out without a falling edge
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= ST_IDLE;
            r_bitcnt   <= '0;
            r_shift    <= '0;
            r_par      <= 1'b0;
            r_timer    <= '0;
            r_push     <= 1'b0;
            r_perr_set <= 1'b0;
            r_ferr_set <= 1'b0;
        end else begin
            r_push     <= 1'b0;
            r_perr_set <= 1'b0;
            r_ferr_set <= 1'b0;
            if (r_state == ST_IDLE) begin
                r_timer <= '0;
                if (r_fall && !r_dat_filt) begin
                    r_state  <= ST_DATA;
                    r_bitcnt <= '0;
                end
            end else if (r_fall) begin
                r_timer <= '0;
                case (r_state)
                    ST_DATA: begin
                        r_shift  <= {r_dat_filt, r_shift[7:1]};
                        r_bitcnt <= r_bitcnt + 3'd1;
                        if (r_bitcnt == 3'd7) r_state <= ST_PARITY;
                    end
                    ST_PARITY: begin
                        r_par   <= r_dat_filt;
                        r_state <= ST_STOP;
                    end
                    default: begin
                        r_push     <= r_dat_filt & (^{r_shift, r_par});
                        r_perr_set <= ~(^{r_shift, r_par});
                        r_ferr_set <= ~r_dat_filt;
                        r_state    <= ST_IDLE;
                    end
                endcase
            end else if (r_timer == TW'(TIMEOUT - 1)) begin
                r_ferr_set <= 1'b1;
                r_state    <= ST_IDLE;
            end else begin
                r_timer <= r_timer + TW'(1);
            end
        end
    end

    ps2_fifo #(.AW(FIFO_AWIDTH)) u_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .i_push    (r_push),
        .i_wdata   (r_shift),
        .i_pop     (w_pop),
        .i_flush   (w_flush),
        .o_rdata_c (w_fifo_data),
        .o_full_c  (w_full),
        .o_empty_c (w_empty),
        .o_count   (w_count)
    );

    assign w_req     = bus.cyc & bus.stb & ~r_ack;
    assign w_wr      = w_req & bus.we;
    assign w_rd      = w_req & ~bus.we;
    assign w_sel     = bus.adr[3:2];
    assign w_pop     = w_rd & (w_sel == REG_DATA) & ~w_empty;
    assign w_flush   = w_wr & (w_sel == REG_CTRL) & bus.dat_i[CTRL_FLUSH_BIT];
    assign w_clr     = (w_wr && w_sel == REG_STATUS) ? bus.dat_i[3:1] : 3'b000;
    assign w_ovf_set = r_push & w_full & ~w_pop;

    always_comb begin
        w_rdata = '0;
        case (w_sel)
            REG_DATA: begin
                if (!w_empty) w_rdata[8:0] = {1'b1, w_fifo_data};
            end
            REG_STATUS: begin
                w_rdata[STAT_NEMPTY_BIT]             = ~w_empty;
                w_rdata[STAT_PERR_BIT]               = r_perr;
                w_rdata[STAT_FERR_BIT]               = r_ferr;
                w_rdata[STAT_OVF_BIT]                = r_ovf;
                w_rdata[STAT_COUNT_LSB +: CW]        = w_count;
            end
            REG_CTRL: w_rdata[CTRL_IE_BIT] = r_ie;
            default:  w_rdata = '0;
        endcase
    end

    // Bus response, control/status registers and interrupt; flag set beats clear
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ack   <= 1'b0;
            r_dat_o <= '0;
            r_ie    <= 1'b0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovf   <= 1'b0;
            r_irq   <= 1'b0;
        end else begin
            r_ack <= w_req;
            if (w_req) r_dat_o <= w_rdata;
            if (w_wr && w_sel == REG_CTRL) r_ie <= bus.dat_i[CTRL_IE_BIT];
            r_perr <= r_perr_set | (r_perr & ~w_clr[STAT_PERR_BIT]);
            r_ferr <= r_ferr_set | (r_ferr & ~w_clr[STAT_FERR_BIT]);
            r_ovf  <= w_ovf_set  | (r_ovf  & ~w_clr[STAT_OVF_BIT]);
            r_irq  <= r_ie & ~w_empty;
        end
    end

    assign bus.ack    = r_ack;
    assign bus.dat_o  = r_dat_o;
    assign interrupt  = r_irq;

    assign w_unused_ok = &{1'b0, bus.adr[31:4], bus.adr[1:0], bus.dat_i[31:4]};

endmodule

// File: tb/tb_ps2_kbd.sv
// Directed bench for ps2_kbd: frames, errors, overflow, timeout, interrupt, glitch, reset.
`timescale 1ns/1ps
module tb_ps2_kbd;

    logic clk;
    logic rst_i;
    logic ps2_clk;
    logic ps2_dat;
    logic interrupt;
    logic irq_at_ack;
    int   n_assert;
    int   n_fail;

    if_wb bus ();

    ps2_kbd #(.CLKFREQ(1000000), .FIFO_AWIDTH(4)) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .bus       (bus),
        .ps2_clk   (ps2_clk),
        .ps2_dat   (ps2_dat),
        .interrupt (interrupt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic odd_par(input logic [7:0] b);
        return ~^b;
    endfunction

    // 40-cycle bit period: data set, 10 high, 20 low, 10 high
    task automatic send_frame(input logic [7:0] b, input logic par, input logic stop, input int nbits);
        logic [10:0] bits;
        bits = {stop, par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_dat = bits[i];
            repeat (10) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (20) @(negedge clk);
            ps2_clk = 1'b1;
            repeat (10) @(negedge clk);
        end
        ps2_dat = 1'b1;
    endtask

    task automatic send_good(input logic [7:0] b);
        send_frame(b, odd_par(b), 1'b1, 11);
    endtask

    task automatic wb_rd(input logic [31:0] a, output logic [31:0] d);
        bit got;
        got = 1'b0;
        d = '0;
        bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b0; bus.adr = a; bus.dat_i = '0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (bus.ack === 1'b1) begin
                got = 1'b1;
                d = bus.dat_o;
                irq_at_ack = interrupt;
            end
        end
        bus.cyc = 1'b0; bus.stb = 1'b0;
        if (!got) chk("rd_ack_timeout", 32'(got), 32'd1);
    endtask

    task automatic wb_wr(input logic [31:0] a, input logic [31:0] d);
        bit got;
        got = 1'b0;
        bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b1; bus.adr = a; bus.dat_i = d;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (bus.ack === 1'b1) got = 1'b1;
        end
        bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
        if (!got) chk("wr_ack_timeout", 32'(got), 32'd1);
    endtask

    initial begin
        logic [31:0] rd;
        n_assert = 0;
        n_fail   = 0;
        irq_at_ack = 1'b0;
        rst_i = 1'b1;
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0; bus.adr = '0; bus.dat_i = '0;
        repeat (4) @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);

        chk("rst_ack", 32'(bus.ack), 32'd0);
        chk("rst_dat_o", bus.dat_o, 32'd0);
        chk("rst_irq", 32'(interrupt), 32'd0);
        wb_rd(32'h4, rd); chk("rst_status", rd, 32'h0);
        @(negedge clk);
        chk("ack_single_pulse", 32'(bus.ack), 32'd0);
        wb_rd(32'h0, rd); chk("rst_data_empty", rd, 32'h0);

        // Single byte
        send_frame(8'h1C, 1'b0, 1'b1, 11);
        wb_rd(32'h4, rd); chk("single_status", rd, 32'h101);
        wb_rd(32'h0, rd); chk("single_data", rd, 32'h11C);
        wb_rd(32'h4, rd); chk("single_status_after", rd, 32'h0);

        // Parity error
        send_frame(8'h1C, 1'b1, 1'b1, 11);
        wb_rd(32'h4, rd); chk("perr_status", rd, 32'h2);
        wb_wr(32'h4, 32'h2);
        wb_rd(32'h4, rd); chk("perr_cleared", rd, 32'h0);

        // Stop bit 0 -> framing error, no push
        send_frame(8'h1C, 1'b0, 1'b0, 11);
        ps2_dat = 1'b1;
        wb_rd(32'h4, rd); chk("stop_ferr_status", rd, 32'h4);
        wb_wr(32'h4, 32'h4);

        // Overflow
        for (int i = 0; i < 17; i++) send_good(8'(i));
        wb_rd(32'h4, rd); chk("ovf_status", rd, 32'h1009);
        for (int i = 0; i < 16; i++) begin
            wb_rd(32'h0, rd); chk("ovf_data", rd, 32'h100 + 32'(i));
        end
        wb_rd(32'h0, rd); chk("ovf_data_17th", rd, 32'h0);
        wb_wr(32'h4, 32'h8);
        wb_rd(32'h4, rd); chk("ovf_cleared", rd, 32'h0);

        // Timeout
        send_frame(8'h00, 1'b1, 1'b1, 4);
        repeat (2100) @(negedge clk);
        wb_rd(32'h4, rd); chk("timeout_ferr", rd, 32'h4);
        wb_wr(32'h4, 32'h4);
        send_good(8'hF0);
        wb_rd(32'h4, rd); chk("timeout_next_status", rd, 32'h101);
        wb_rd(32'h0, rd); chk("timeout_next_data", rd, 32'h1F0);

        // CTRL, flush, unused offset
        send_good(8'h1C);
        wb_wr(32'hC, 32'hFFFF_FFFF);
        wb_wr(32'h0, 32'hFFFF_FFFF);
        wb_rd(32'hC, rd); chk("rsvd_read", rd, 32'h0);
        wb_wr(32'h8, 32'h3);
        wb_rd(32'h4, rd); chk("flush_status", rd, 32'h0);
        wb_rd(32'h8, rd); chk("ctrl_readback", rd, 32'h1);
        chk("irq_after_flush", 32'(interrupt), 32'd0);

        // Interrupt timing around the stop-bit edge
        send_frame(8'h5A, odd_par(8'h5A), 1'b1, 10);
        ps2_dat = 1'b1;
        repeat (10) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (9) @(negedge clk);
        chk("irq_before_rise", 32'(interrupt), 32'd0);
        @(negedge clk);
        chk("irq_rise", 32'(interrupt), 32'd1);
        wb_rd(32'h0, rd); chk("irq_data", rd, 32'h15A);
        chk("irq_at_ack", 32'(irq_at_ack), 32'd1);
        @(negedge clk);
        chk("irq_fall", 32'(interrupt), 32'd0);
        ps2_clk = 1'b1;
        repeat (20) @(negedge clk);

        // Glitch: 2-cycle low pulse with data low must not start a frame
        ps2_dat = 1'b0;
        repeat (5) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (2) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (5) @(negedge clk);
        ps2_dat = 1'b1;
        repeat (30) @(negedge clk);
        send_good(8'h33);
        wb_rd(32'h4, rd); chk("glitch_status", rd, 32'h101);
        wb_rd(32'h0, rd); chk("glitch_data", rd, 32'h133);

        // Reset mid-frame with a byte buffered and interrupt high
        send_good(8'h77);
        chk("pre_rst_irq", 32'(interrupt), 32'd1);
        wb_rd(32'h4, rd); chk("pre_rst_status", rd, 32'h101);
        send_frame(8'h29, odd_par(8'h29), 1'b1, 6);
        rst_i = 1'b1;
        repeat (2) @(negedge clk);
        rst_i = 1'b0;
        chk("midrst_ack", 32'(bus.ack), 32'd0);
        chk("midrst_dat_o", bus.dat_o, 32'd0);
        chk("midrst_irq", 32'(interrupt), 32'd0);
        wb_rd(32'h4, rd); chk("midrst_status", rd, 32'h0);
        wb_rd(32'h8, rd); chk("midrst_ctrl", rd, 32'h0);
        repeat (20) @(negedge clk);
        send_good(8'h29);
        wb_rd(32'h0, rd); chk("midrst_next_data", rd, 32'h129);
        wb_rd(32'h4, rd); chk("midrst_final_status", rd, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
